timer_sched: RTL and testbench

Round-robin scheduler that time-shares one loadable up-counter among NREQ requesters, each asking for a timeout of a programmable number of cycles. It sits beside the shared counter, drives that counter's load/enable/data inputs, monitors its output, and returns a one-cycle done pulse to the requester whose timeout expired. Only one timeout is in flight at a time.

---
 rtl/timer_sched_pkg.sv | 54 +++++
 rtl/timer_sched_rr_arbiter.sv | 31 +++
 rtl/timer_sched.sv | 154 +++++++++++++++
 tb/tb_timer_sched.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_sched_pkg.sv
// -----------------------------------------------------------------------------
// timer_sched_pkg
// Shared types and helpers for the timer_sched round-robin timeout scheduler.
//   state_t  : scheduler FSM state (2-bit)
//   DEF_*    : default configuration (NREQ, WIDTH) and default pointer width
//   rr_pick  : round-robin winner index (lowest requesting index >= ptr,
//              wrapping modulo n)
// -----------------------------------------------------------------------------
package timer_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam int DEF_NREQ  = 4;
    localparam int DEF_WIDTH = 5;
    localparam int DEF_PTR_W = $clog2(DEF_NREQ);

    // Largest supported requester count; the helper works on a vector of
    // this size so it serves every legal NREQ.
    localparam int MAX_NREQ  = 16;
    localparam int IDX_W     = $clog2(MAX_NREQ);

    // Returns the first requesting index found when scanning ptr, ptr+1, ...
    // modulo n. Returns 0 when nothing requests; callers qualify with |req.
    function automatic int rr_pick(input logic [MAX_NREQ-1:0] req,
                                   input int                  ptr,
                                   input int                  n);
        int   cand;
        int   win;
        logic found;
        win   = 0;
        found = 1'b0;
        cand  = 0;
        for (int k = 0; k < MAX_NREQ; k++) begin
            if (k < n && !found) begin
                // ptr < n and k < n, so a single conditional subtract wraps.
                cand = ptr + k;
                if (cand >= n) begin
                    cand = cand - n;
                end
                if (req[cand[IDX_W-1:0]]) begin
                    win   = cand;
                    found = 1'b1;
                end
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/timer_sched_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin arbiter used by timer_sched.
// Ports:
//   i_req   [NREQ]  : request vector
//   i_ptr   [PTR_W] : round-robin start index (highest priority)
//   o_win   [NREQ]  : one-hot winner, all zero when no request
//   o_idx   [PTR_W] : winner index (0 when no request)
//   o_valid         : at least one request present
// -----------------------------------------------------------------------------
module rr_arbiter
    import timer_sched_pkg::*;
#(
    parameter int NREQ  = DEF_NREQ,
    parameter int PTR_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  i_req,
    input  logic [PTR_W-1:0] i_ptr,
    output logic [NREQ-1:0]  o_win,
    output logic [PTR_W-1:0] o_idx,
    output logic             o_valid
);

    logic [MAX_NREQ-1:0] w_req_ext;

    assign w_req_ext = MAX_NREQ'(i_req);
    assign o_valid   = |i_req;
    assign o_idx     = PTR_W'(rr_pick(w_req_ext, int'(i_ptr), NREQ));
    assign o_win     = o_valid ? (NREQ'(1) << o_idx) : '0;

endmodule

// File: rtl/timer_sched.sv
// -----------------------------------------------------------------------------
// timer_sched
// Round-robin scheduler time-sharing one external loadable up-counter among
// NREQ requesters. One timeout is in flight at a time: the winner is granted,
// the counter is loaded with 0, enabled until it equals the winner's duration,
// and a one-cycle done pulse is returned to that requester.
//
// Ports:
//   clk       : clock, posedge
//   rst       : synchronous active-high reset
//   req  [N]  : level request per requester, held until done
//   dur  [N*W]: duration per requester, slice i = dur[i*WIDTH +: WIDTH]
//   grant[N]  : one-hot acceptance pulse (combinational from req in IDLE)
//   done [N]  : one-hot expiry pulse to the owner
//   busy      : high while a timeout is in flight (LOAD, RUN, DONE)
//   cnt_load  : counter load strobe
//   cnt_enab  : counter increment enable
//   cnt_in[W] : counter load value, constant 0
//   cnt_val[W]: counter registered output
//
// Build option:
//   TIMER_SCHED_ABORT_EN : when defined, dropping req[owner] during LOAD or
//                          RUN returns to IDLE without a done pulse.
// -----------------------------------------------------------------------------
module timer_sched
    import timer_sched_pkg::*;
#(
    parameter int NREQ  = DEF_NREQ,
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] dur,
    output logic [NREQ-1:0]       grant,
    output logic [NREQ-1:0]       done,
    output logic                  busy,
    output logic                  cnt_load,
    output logic                  cnt_enab,
    output logic [WIDTH-1:0]      cnt_in,
    input  logic [WIDTH-1:0]      cnt_val
);

    localparam int PTR_W = $clog2(NREQ);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [PTR_W-1:0]  r_ptr;
    logic [PTR_W-1:0]  r_owner;
    logic [WIDTH-1:0]  r_dur_q;

    logic [NREQ-1:0]   w_win;
    logic [PTR_W-1:0]  w_idx;
    logic              w_valid;
    logic              w_take;
    logic              w_match;
    logic              w_abort;
    logic [PTR_W-1:0]  w_ptr_nxt;
    logic [WIDTH-1:0]  w_dur_sel;

    rr_arbiter #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_arb (
        .i_req   (req),
        .i_ptr   (r_ptr),
        .o_win   (w_win),
        .o_idx   (w_idx),
        .o_valid (w_valid)
    );

    assign w_take    = (r_state == ST_IDLE) && w_valid;
    assign w_match   = (cnt_val == r_dur_q);
    assign w_ptr_nxt = (w_idx == PTR_W'(NREQ - 1)) ? '0 : w_idx + 1'b1;

`ifdef TIMER_SCHED_ABORT_EN
    assign w_abort = !req[r_owner];
`else
    assign w_abort = 1'b0;
`endif

    // Duration slice of the current arbitration winner.
    always_comb begin
        w_dur_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_idx == PTR_W'(i)) begin
                w_dur_sel = dur[i*WIDTH +: WIDTH];
            end
        end
    end

    // Next state and outputs. Everything except grant is decoded from
    // registered state (plus the counter's registered output), so req never
    // reaches cnt_load/cnt_enab combinationally.
    always_comb begin
        // NOTE: every output of this block gets a default before the case so
        // no path leaves a signal unassigned (which would infer a latch).
        w_state_nxt = r_state;
        grant       = '0;
        done        = '0;
        busy        = 1'b1;
        cnt_load    = 1'b0;
        cnt_enab    = 1'b0;
        cnt_in      = '0;
        case (r_state)
            ST_IDLE: begin
                busy  = 1'b0;
                grant = w_win;
                if (w_valid) begin
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                cnt_load    = 1'b1;
                w_state_nxt = w_abort ? ST_IDLE : ST_RUN;
            end
            ST_RUN: begin
                // Equality stop: the counter halts at r_dur_q and never wraps.
                cnt_enab = !w_match;
                if (w_abort) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_match) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                done        = NREQ'(1) << r_owner;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
            r_owner <= '0;
            r_dur_q <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_take) begin
                r_owner <= w_idx;
                r_ptr   <= w_ptr_nxt;
                r_dur_q <= w_dur_sel;
            end
        end
    end

endmodule

// File: tb/tb_timer_sched.sv
// -----------------------------------------------------------------------------
// tb_timer_sched
// Self-checking bench for timer_sched. Models the attached up-counter,
// predicts every output per cycle from a transaction-level reference
// (grant time, duration, owner), and adds directed table and sequence checks.
// Honours TIMER_SCHED_ABORT_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_timer_sched;

    localparam int NREQ     = 4;
    localparam int WIDTH    = 5;
    localparam int CLK_HALF = 5;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [NREQ-1:0]       req = '0;
    logic [NREQ*WIDTH-1:0] dur = '0;
    logic [NREQ-1:0]       grant;
    logic [NREQ-1:0]       done;
    logic                  busy;
    logic                  cnt_load;
    logic                  cnt_enab;
    logic [WIDTH-1:0]      cnt_in;
    logic [WIDTH-1:0]      cnt_val;

    always #CLK_HALF clk = ~clk;

    // Shared loadable up-counter attached beside the scheduler.
    always @(posedge clk) begin
        if (rst)           cnt_val <= '0;
        else if (cnt_load) cnt_val <= cnt_in;
        else if (cnt_enab) cnt_val <= cnt_val + 1'b1;
    end

    timer_sched #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .dur      (dur),
        .grant    (grant),
        .done     (done),
        .busy     (busy),
        .cnt_load (cnt_load),
        .cnt_enab (cnt_enab),
        .cnt_in   (cnt_in),
        .cnt_val  (cnt_val)
    );

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    // Reference model: one in-flight transaction described by its grant
    // cycle, duration and owner; outputs follow from cycle offsets.
    bit m_active = 1'b0;
    int m_t0, m_d, m_owner, m_end;
    int m_ptr    = 0;

    logic [NREQ-1:0]  e_grant, e_done;
    logic             e_busy, e_load, e_enab;
    logic [NREQ-1:0]  s_grant, s_done;
    logic             s_busy, s_load, s_enab;
    logic [WIDTH-1:0] s_cnt_in, s_cnt_val;

    typedef struct {
        logic                  rst;
        logic [NREQ-1:0]       req;
        logic [NREQ*WIDTH-1:0] dur;
        logic [NREQ-1:0]       grant;
        logic [NREQ-1:0]       done;
        logic                  busy;
        logic                  load;
        logic                  enab;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [NREQ*WIDTH-1:0] pack(input int d0, input int d1, input int d2, input int d3);
        return {WIDTH'(d3), WIDTH'(d2), WIDTH'(d1), WIDTH'(d0)};
    endfunction

    function automatic int onehot_idx(input logic [NREQ-1:0] v);
        for (int i = 0; i < NREQ; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic vec_t mk(input logic r, input logic [NREQ-1:0] q, input logic [NREQ*WIDTH-1:0] d,
                                input logic [NREQ-1:0] g, input logic [NREQ-1:0] dn,
                                input logic b, input logic l, input logic e);
        vec_t v;
        v.rst = r; v.req = q; v.dur = d; v.grant = g; v.done = dn;
        v.busy = b; v.load = l; v.enab = e;
        return v;
    endfunction

    task automatic model_eval(input logic i_rst, input logic [NREQ-1:0] i_req,
                              input logic [NREQ*WIDTH-1:0] i_dur);
        int rel;
        int c;
        bit hit;
        e_grant = '0; e_done = '0; e_busy = 1'b0; e_load = 1'b0; e_enab = 1'b0;
        hit = 1'b0;
        if (m_active && cyc >= m_end) m_active = 1'b0;
        if (!m_active) begin
            for (int k = 0; k < NREQ; k++) begin
                c = (m_ptr + k) % NREQ;
                if (!hit && i_req[c]) begin
                    hit        = 1'b1;
                    e_grant[c] = 1'b1;
                    m_active   = 1'b1;
                    m_t0       = cyc;
                    m_d        = int'(i_dur[c*WIDTH +: WIDTH]);
                    m_owner    = c;
                    m_ptr      = (c + 1) % NREQ;
                    m_end      = cyc + 4 + m_d;
                end
            end
        end else begin
            rel    = cyc - m_t0;
            e_busy = 1'b1;
            e_load = (rel == 1);
            e_enab = (rel >= 2) && (rel < 2 + m_d);
            if (rel == 3 + m_d) e_done[m_owner] = 1'b1;
`ifdef TIMER_SCHED_ABORT_EN
            if (rel <= 2 + m_d && !i_req[m_owner]) m_end = cyc + 1;
`endif
        end
        if (i_rst) begin
            m_active = 1'b0;
            m_ptr    = 0;
        end
    endtask

    // One clock cycle: drive after the falling edge, sample 1 time unit later,
    // compare against the model, then let the rising edge happen.
    task automatic step(input logic i_rst, input logic [NREQ-1:0] i_req,
                        input logic [NREQ*WIDTH-1:0] i_dur);
        @(negedge clk);
        rst = i_rst;
        req = i_req;
        dur = i_dur;
        #1;
        s_grant = grant; s_done = done; s_busy = busy;
        s_load = cnt_load; s_enab = cnt_enab; s_cnt_in = cnt_in; s_cnt_val = cnt_val;
        model_eval(i_rst, i_req, i_dur);
        check($sformatf("c%0d grant", cyc),    32'(s_grant),  32'(e_grant));
        check($sformatf("c%0d done", cyc),     32'(s_done),   32'(e_done));
        check($sformatf("c%0d busy", cyc),     32'(s_busy),   32'(e_busy));
        check($sformatf("c%0d cnt_load", cyc), 32'(s_load),   32'(e_load));
        check($sformatf("c%0d cnt_enab", cyc), 32'(s_enab),   32'(e_enab));
        check($sformatf("c%0d cnt_in", cyc),   32'(s_cnt_in), 32'd0);
        cyc++;
    endtask

    initial begin
        #(CLK_HALF * 2 * 40000);
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
        $fatal(1);
    end

    initial begin
        logic [NREQ*WIDTH-1:0] d1, d1b, d0;
        d1  = pack(0, 3, 0, 0);
        d1b = pack(0, 9, 0, 0);   // changed after grant; must be ignored
        d0  = pack(0, 0, 0, 0);

        // ---- directed table: reset, req[1] dur=3, then req[2] dur=0 ----
        //                 rst  req      dur  grant    done     busy load enab
        tbl.push_back(mk(1, 4'b0000, d1,  4'b0000, 4'b0000, 0, 0, 0));
        tbl.push_back(mk(1, 4'b0000, d1,  4'b0000, 4'b0000, 0, 0, 0));
        tbl.push_back(mk(0, 4'b0010, d1,  4'b0010, 4'b0000, 0, 0, 0));
        tbl.push_back(mk(0, 4'b0010, d1b, 4'b0000, 4'b0000, 1, 1, 0));
        tbl.push_back(mk(0, 4'b0010, d1b, 4'b0000, 4'b0000, 1, 0, 1));
        tbl.push_back(mk(0, 4'b0010, d1b, 4'b0000, 4'b0000, 1, 0, 1));
        tbl.push_back(mk(0, 4'b0010, d1b, 4'b0000, 4'b0000, 1, 0, 1));
        tbl.push_back(mk(0, 4'b0010, d1b, 4'b0000, 4'b0000, 1, 0, 0));
        tbl.push_back(mk(0, 4'b0010, d1b, 4'b0000, 4'b0010, 1, 0, 0));
        tbl.push_back(mk(0, 4'b0000, d1b, 4'b0000, 4'b0000, 0, 0, 0));
        tbl.push_back(mk(0, 4'b0100, d0,  4'b0100, 4'b0000, 0, 0, 0));
        tbl.push_back(mk(0, 4'b0100, d0,  4'b0000, 4'b0000, 1, 1, 0));
        tbl.push_back(mk(0, 4'b0100, d0,  4'b0000, 4'b0000, 1, 0, 0));
        tbl.push_back(mk(0, 4'b0100, d0,  4'b0000, 4'b0100, 1, 0, 0));
        tbl.push_back(mk(0, 4'b0000, d0,  4'b0000, 4'b0000, 0, 0, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].rst, tbl[i].req, tbl[i].dur);
            check($sformatf("tbl%0d grant", i), 32'(s_grant), 32'(tbl[i].grant));
            check($sformatf("tbl%0d done", i),  32'(s_done),  32'(tbl[i].done));
            check($sformatf("tbl%0d busy", i),  32'(s_busy),  32'(tbl[i].busy));
            check($sformatf("tbl%0d load", i),  32'(s_load),  32'(tbl[i].load));
            check($sformatf("tbl%0d enab", i),  32'(s_enab),  32'(tbl[i].enab));
        end

        // ---- all four held, dur=1: grants 0,1,2,3,0 five cycles apart ----
        begin
            int gcyc[$];
            int gidx[$];
            int exp_ord[5] = '{0, 1, 2, 3, 0};
            step(1, '0, '0);
            for (int c = 0; c < 24; c++) begin
                step(0, 4'hF, pack(1, 1, 1, 1));
                if (s_grant != 0) begin
                    gcyc.push_back(c);
                    gidx.push_back(onehot_idx(s_grant));
                end
            end
            check("rr grant count", 32'(gidx.size()), 32'd5);
            for (int k = 0; k < 5; k++) begin
                if (k < gidx.size()) begin
                    check($sformatf("rr order %0d", k), 32'(gidx[k]), 32'(exp_ord[k]));
                    if (k > 0) check($sformatf("rr spacing %0d", k), 32'(gcyc[k] - gcyc[k-1]), 32'd5);
                end
            end
            for (int c = 0; c < 8; c++) step(0, '0, '0);
        end

        // ---- ptr=2 after grant to 1; req[0],req[3] -> 3 first, then 0 ----
        begin
            int order[$];
            logic [NREQ-1:0] h;
            bit phase2;
            h = 4'b0010;
            phase2 = 1'b0;
            step(1, '0, '0);
            for (int c = 0; c < 40; c++) begin
                step(0, h, '0);
                if (phase2 && s_grant != 0) order.push_back(onehot_idx(s_grant));
                h = h & ~e_done;
                if (!phase2 && e_done[1]) begin
                    phase2 = 1'b1;
                    h = 4'b1001;
                end
            end
            check("ptr2 grant count", 32'(order.size()), 32'd2);
            if (order.size() == 2) begin
                check("ptr2 first grant", 32'(order[0]), 32'd3);
                check("ptr2 second grant", 32'(order[1]), 32'd0);
            end
        end

        // ---- reset during RUN at cnt_val=2, then restart from ptr 0 ----
        begin
            logic [NREQ*WIDTH-1:0] dc;
            logic [NREQ-1:0] h;
            int done_seen;
            dc = pack(5, 0, 0, 0);
            done_seen = 0;
            step(1, '0, '0);
            step(0, 4'b0001, dc);
            check("rstrun grant", 32'(s_grant), 32'b0001);
            for (int c = 0; c < 3; c++) step(0, 4'b0001, dc);
            step(1, 4'b0001, dc);
            check("rstrun cnt_val at reset", 32'(s_cnt_val), 32'd2);
            check("rstrun enab at reset", 32'(s_enab), 32'd1);
            step(0, '0, dc);
            check("rstrun outputs after reset",
                  32'({s_grant, s_done, s_busy, s_load, s_enab}), 32'd0);
            for (int c = 0; c < 10; c++) begin
                step(0, '0, dc);
                if (s_done != 0) done_seen++;
            end
            check("rstrun no done", 32'(done_seen), 32'd0);
            h = 4'b0011;
            step(0, h, pack(2, 2, 0, 0));
            check("rstrun ptr restarts at 0", 32'(s_grant), 32'b0001);
            h = h & ~e_done;
            for (int c = 0; c < 40 && h != 0; c++) begin
                step(0, h, pack(2, 2, 0, 0));
                h = h & ~e_done;
            end
            check("rstrun requests served", 32'(h), 32'd0);
            for (int c = 0; c < 4; c++) step(0, '0, '0);
        end

        // ---- drop req[owner] during RUN ----
        begin
            logic [NREQ*WIDTH-1:0] dd;
            int done_rel;
            logic busy_rel5;
            dd = pack(0, 0, 6, 0);
            done_rel  = -1;
            busy_rel5 = 1'b1;
            step(1, '0, '0);
            step(0, 4'b0100, dd);
            check("drop grant", 32'(s_grant), 32'b0100);
            for (int rel = 1; rel <= 3; rel++) step(0, 4'b0100, dd);
            step(0, '0, dd);
            for (int rel = 5; rel <= 14; rel++) begin
                step(0, '0, dd);
                if (rel == 5) busy_rel5 = s_busy;
                if (s_done != 0 && done_rel < 0) done_rel = rel;
            end
`ifdef TIMER_SCHED_ABORT_EN
            check("abort busy next cycle", 32'(busy_rel5), 32'd0);
            check("abort no done", 32'(done_rel), 32'hFFFF_FFFF);
`else
            check("no-abort busy continues", 32'(busy_rel5), 32'd1);
            check("no-abort done cycle", 32'(done_rel), 32'd9);
`endif
        end

        // ---- randomized traffic against the reference model ----
        begin
            logic [NREQ-1:0] h;
            logic [NREQ*WIDTH-1:0] d;
            logic r;
            h = '0;
            step(1, '0, '0);
            for (int c = 0; c < 1500; c++) begin
                r = ($urandom_range(0, 299) == 0);
                for (int i = 0; i < NREQ; i++) begin
                    if (!h[i] && $urandom_range(0, 3) == 0) h[i] = 1'b1;
`ifdef TIMER_SCHED_ABORT_EN
                    if (h[i] && $urandom_range(0, 39) == 0) h[i] = 1'b0;
`endif
                    d[i*WIDTH +: WIDTH] = ($urandom_range(0, 31) == 0) ? WIDTH'(31)
                                                                       : WIDTH'($urandom_range(0, 6));
                end
                step(r, h, d);
                h = h & ~e_done;
                if (r) h = '0;
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
